// File: rtl/cnn_layer_accel_dispatch_pkg.sv
// Shared types, default sizes and the round-robin picker for the job dispatcher.
package cnn_layer_accel_dispatch_pkg;

  localparam int unsigned DEF_NUM_QUADS  = 4;
  localparam int unsigned DEF_JOB_W      = 128;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_CNT_W      = 32;
  localparam int unsigned MAX_QUADS      = 16;
  localparam int unsigned QIDX_W         = 4;

  typedef enum logic [2:0] {
    Q_IDLE,
    Q_START,
    Q_RUN,
    Q_FETCH,
    Q_DONE
  } quad_state_t;

  typedef struct packed {
    logic              valid;
    logic [QIDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of idle_vec at or after ptr, searched modulo n (ptr < n assumed).
  function automatic rr_pick_t rr_select(input logic [MAX_QUADS-1:0] idle_vec,
                                         input logic [QIDX_W-1:0]    ptr,
                                         input int unsigned          n);
    rr_pick_t    pick;
    int unsigned j;
    pick = '0;
    for (int unsigned i = 0; i < MAX_QUADS; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) j = j - n;
      if (!pick.valid && (i < n) && idle_vec[j[QIDX_W-1:0]]) begin
        pick.valid = 1'b1;
        pick.idx   = j[QIDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_job_fifo.sv
// Synchronous job-descriptor FIFO; head word is visible combinationally (first-word fall-through).
module cnn_layer_accel_job_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_core,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk_core) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cnn_layer_accel_job_dispatch.sv
// Queues host job descriptors and hands them round-robin to idle quads, running
// the start / fetch / complete handshakes per quad and counting finished jobs.
module cnn_layer_accel_job_dispatch
  import cnn_layer_accel_dispatch_pkg::*;
#(
  parameter int unsigned NUM_QUADS  = DEF_NUM_QUADS,
  parameter int unsigned JOB_W      = DEF_JOB_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                         clk_core,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         host_job_valid,
  output logic                         host_job_ready,
  input  logic [JOB_W-1:0]             host_job_data,
  output logic [NUM_QUADS-1:0]         job_start,
  input  logic [NUM_QUADS-1:0]         job_accept,
  output logic [NUM_QUADS*JOB_W-1:0]   job_parameters,
  input  logic [NUM_QUADS-1:0]         job_fetch_request,
  output logic [NUM_QUADS-1:0]         job_fetch_ack,
  output logic [NUM_QUADS-1:0]         fetch_busy,
  input  logic [NUM_QUADS-1:0]         fetch_done,
  output logic [NUM_QUADS-1:0]         job_fetch_complete,
  input  logic [NUM_QUADS-1:0]         job_complete,
  output logic [NUM_QUADS-1:0]         job_complete_ack,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [NUM_QUADS-1:0]         quads_busy,
  output logic [CNT_W-1:0]             jobs_completed,
  output logic                         idle
);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [JOB_W-1:0]      fifo_head;
  logic                  dispatch;
  rr_pick_t              disp_pick;
  logic [QIDX_W-1:0]     rr_ptr_reg;
  logic [QIDX_W-1:0]     rr_ptr_next;
  logic [NUM_QUADS-1:0]  quad_idle;
  logic [NUM_QUADS-1:0]  quad_done;
  logic [MAX_QUADS-1:0]  idle_pad;
  logic [CNT_W-1:0]      done_sum;
  logic [CNT_W-1:0]      jobs_completed_reg;

  cnn_layer_accel_job_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_core (clk_core),
    .rst      (rst),
    .push     (host_job_valid),
    .wr_data  (host_job_data),
    .pop      (dispatch),
    .rd_data  (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign host_job_ready = ~fifo_full;

  always_comb begin
    idle_pad                = '0;
    idle_pad[NUM_QUADS-1:0] = quad_idle;
  end

  assign disp_pick = rr_select(idle_pad, rr_ptr_reg, NUM_QUADS);
  assign dispatch  = enable & ~fifo_empty & disp_pick.valid;

  always_comb begin
    rr_ptr_next = disp_pick.idx + 1'b1;
    if (disp_pick.idx == QIDX_W'(NUM_QUADS - 1)) rr_ptr_next = '0;
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst)          rr_ptr_reg <= '0;
    else if (dispatch) rr_ptr_reg <= rr_ptr_next;
  end

  for (genvar gi = 0; gi < NUM_QUADS; gi++) begin : g_quad
    quad_state_t      state_reg;
    quad_state_t      state_next;
    logic             fetch_ack_reg;
    logic             fetch_ack_next;
    logic             fetch_cmp_reg;
    logic             fetch_cmp_next;
    logic [JOB_W-1:0] params_reg;
    logic             win;

    assign win = dispatch && (disp_pick.idx == QIDX_W'(gi));

    always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
        state_reg     <= Q_IDLE;
        fetch_ack_reg <= 1'b0;
        fetch_cmp_reg <= 1'b0;
        params_reg    <= '0;
      end else begin
        state_reg     <= state_next;
        fetch_ack_reg <= fetch_ack_next;
        fetch_cmp_reg <= fetch_cmp_next;
        if (win) params_reg <= fifo_head;
      end
    end

    // Completion beats a simultaneous fetch request; completion during FETCH is dropped.
    always_comb begin
      state_next     = state_reg;
      fetch_ack_next = 1'b0;
      fetch_cmp_next = 1'b0;
      case (state_reg)
        Q_IDLE:  if (win) state_next = Q_START;
        Q_START: if (job_accept[gi]) state_next = Q_RUN;
        Q_RUN: begin
          if (job_complete[gi]) begin
            state_next = Q_DONE;
          end else if (job_fetch_request[gi]) begin
            state_next     = Q_FETCH;
            fetch_ack_next = 1'b1;
          end
        end
        Q_FETCH: begin
          if (fetch_done[gi]) begin
            state_next     = Q_RUN;
            fetch_cmp_next = 1'b1;
          end
        end
        Q_DONE:  state_next = Q_IDLE;
        default: state_next = Q_IDLE;
      endcase
    end

    assign job_start[gi]                    = (state_reg == Q_START);
    assign fetch_busy[gi]                   = (state_reg == Q_FETCH);
    assign job_complete_ack[gi]             = (state_reg == Q_DONE);
    assign job_fetch_ack[gi]                = fetch_ack_reg;
    assign job_fetch_complete[gi]           = fetch_cmp_reg;
    assign quad_idle[gi]                    = (state_reg == Q_IDLE);
    assign quad_done[gi]                    = (state_reg == Q_DONE);
    assign job_parameters[gi*JOB_W +: JOB_W] = params_reg;
  end

  always_comb begin
    done_sum = '0;
    for (int i = 0; i < NUM_QUADS; i++) done_sum = done_sum + CNT_W'(quad_done[i]);
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst)            jobs_completed_reg <= '0;
    else if (|quad_done) jobs_completed_reg <= jobs_completed_reg + done_sum;
  end

  // Status outputs decode state/count registers directly, so they carry no combinational input paths.
  assign jobs_completed = jobs_completed_reg;
  assign quads_busy     = ~quad_idle;
  assign idle           = fifo_empty & (&quad_idle);

endmodule

// File: tb/tb_cnn_layer_accel_job_dispatch.sv
// Randomised and directed bench for the job dispatcher against a queue-based reference model.
module tb_cnn_layer_accel_job_dispatch;

  localparam int NQ = 4;
  localparam int JW = 128;
  localparam int FD = 8;
  localparam int CW = 6;

  logic                 clk_core = 1'b0;
  logic                 rst = 1'b0;
  logic                 enable;
  logic                 host_job_valid;
  logic                 host_job_ready;
  logic [JW-1:0]        host_job_data;
  logic [NQ-1:0]        job_start;
  logic [NQ-1:0]        job_accept;
  logic [NQ*JW-1:0]     job_parameters;
  logic [NQ-1:0]        job_fetch_request;
  logic [NQ-1:0]        job_fetch_ack;
  logic [NQ-1:0]        fetch_busy;
  logic [NQ-1:0]        fetch_done;
  logic [NQ-1:0]        job_fetch_complete;
  logic [NQ-1:0]        job_complete;
  logic [NQ-1:0]        job_complete_ack;
  logic [$clog2(FD):0]  fifo_count;
  logic [NQ-1:0]        quads_busy;
  logic [CW-1:0]        jobs_completed;
  logic                 idle;

  always #5 clk_core = ~clk_core;

  cnn_layer_accel_job_dispatch #(
    .NUM_QUADS  (NQ),
    .JOB_W      (JW),
    .FIFO_DEPTH (FD),
    .CNT_W      (CW)
  ) dut (
    .clk_core           (clk_core),
    .rst                (rst),
    .enable             (enable),
    .host_job_valid     (host_job_valid),
    .host_job_ready     (host_job_ready),
    .host_job_data      (host_job_data),
    .job_start          (job_start),
    .job_accept         (job_accept),
    .job_parameters     (job_parameters),
    .job_fetch_request  (job_fetch_request),
    .job_fetch_ack      (job_fetch_ack),
    .fetch_busy         (fetch_busy),
    .fetch_done         (fetch_done),
    .job_fetch_complete (job_fetch_complete),
    .job_complete       (job_complete),
    .job_complete_ack   (job_complete_ack),
    .fifo_count         (fifo_count),
    .quads_busy         (quads_busy),
    .jobs_completed     (jobs_completed),
    .idle               (idle)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0=idle 1=start 2=run 3=fetch 4=done
  logic [JW-1:0] m_fifo[$];
  int            m_ph[NQ];
  logic [JW-1:0] m_par[NQ];
  logic [NQ-1:0] m_ack;
  logic [NQ-1:0] m_fc;
  int            m_rr;
  logic [CW-1:0] m_done;

  task automatic chk(input string name, input logic [JW-1:0] act, input logic [JW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    for (int q = 0; q < NQ; q++) begin
      m_ph[q]  = 0;
      m_par[q] = '0;
    end
    m_ack  = '0;
    m_fc   = '0;
    m_rr   = 0;
    m_done = '0;
  endtask

  task automatic model_step();
    int            nph[NQ];
    logic [NQ-1:0] nack;
    logic [NQ-1:0] nfc;
    int            w;
    bit            do_push;
    nack    = '0;
    nfc     = '0;
    w       = -1;
    do_push = host_job_valid && (m_fifo.size() < FD);
    for (int q = 0; q < NQ; q++) begin
      nph[q] = m_ph[q];
      case (m_ph[q])
        1: if (job_accept[q]) nph[q] = 2;
        2: begin
          if (job_complete[q]) nph[q] = 4;
          else if (job_fetch_request[q]) begin
            nph[q]  = 3;
            nack[q] = 1'b1;
          end
        end
        3: if (fetch_done[q]) begin
          nph[q] = 2;
          nfc[q] = 1'b1;
        end
        4: begin
          nph[q] = 0;
          m_done = m_done + 1'b1;
          $display("complete quad %0d total %0d", q, m_done);
        end
        default: ;
      endcase
    end
    if (enable && m_fifo.size() > 0) begin
      for (int i = 0; i < NQ; i++) begin
        int c;
        c = (m_rr + i) % NQ;
        if (w < 0 && m_ph[c] == 0) w = c;
      end
    end
    if (w >= 0) begin
      m_par[w] = m_fifo.pop_front();
      nph[w]   = 1;
      m_rr     = (w + 1) % NQ;
      $display("dispatch quad %0d data %h", w, m_par[w]);
    end
    if (do_push) m_fifo.push_back(host_job_data);
    for (int q = 0; q < NQ; q++) m_ph[q] = nph[q];
    m_ack = nack;
    m_fc  = nfc;
  endtask

  task automatic compare_all();
    logic [NQ-1:0] e_start, e_busy, e_cack, e_qb;
    for (int q = 0; q < NQ; q++) begin
      e_start[q] = (m_ph[q] == 1);
      e_busy[q]  = (m_ph[q] == 3);
      e_cack[q]  = (m_ph[q] == 4);
      e_qb[q]    = (m_ph[q] != 0);
      chk($sformatf("job_parameters[%0d]", q), job_parameters[q*JW +: JW], m_par[q]);
    end
    chk("job_start", JW'(job_start), JW'(e_start));
    chk("fetch_busy", JW'(fetch_busy), JW'(e_busy));
    chk("job_complete_ack", JW'(job_complete_ack), JW'(e_cack));
    chk("job_fetch_ack", JW'(job_fetch_ack), JW'(m_ack));
    chk("job_fetch_complete", JW'(job_fetch_complete), JW'(m_fc));
    chk("quads_busy", JW'(quads_busy), JW'(e_qb));
    chk("fifo_count", JW'(fifo_count), JW'(m_fifo.size()));
    chk("host_job_ready", JW'(host_job_ready), JW'(m_fifo.size() < FD));
    chk("idle", JW'(idle), JW'((m_fifo.size() == 0) && (e_qb == '0)));
    chk("jobs_completed", JW'(jobs_completed), JW'(m_done));
  endtask

  task automatic step();
    model_step();
    @(posedge clk_core);
    @(negedge clk_core);
    compare_all();
  endtask

  task automatic clear_inputs();
    enable            = 1'b1;
    host_job_valid    = 1'b0;
    host_job_data     = '0;
    job_accept        = '0;
    job_fetch_request = '0;
    fetch_done        = '0;
    job_complete      = '0;
  endtask

  function automatic logic [JW-1:0] rand_job();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [JW-1:0] a5;
    a5 = {16{8'hA5}};
    clear_inputs();
    model_reset();
    repeat (3) @(negedge clk_core);
    chk("reset idle", JW'(idle), JW'(1));
    chk("reset ready", JW'(host_job_ready), JW'(1));
    chk("reset fifo_count", JW'(fifo_count), JW'(0));
    chk("reset job_start", JW'(job_start), JW'(0));
    rst = 1'b1;
    @(negedge clk_core);
    compare_all();

    // Single job to quad 0, accepted on its third start cycle
    host_job_valid = 1'b1;
    host_job_data  = a5;
    step();
    chk("lit fifo_count after push", JW'(fifo_count), JW'(1));
    chk("lit no start at t+1", JW'(job_start), JW'(0));
    host_job_valid = 1'b0;
    step();
    chk("lit start at t+2", JW'(job_start), JW'(4'b0001));
    chk("lit params q0", job_parameters[0 +: JW], a5);
    chk("lit fifo drained", JW'(fifo_count), JW'(0));
    step();
    job_accept = 4'b0001;
    step();
    job_accept = '0;
    chk("lit start dropped", JW'(job_start), JW'(0));
    chk("lit q0 busy", JW'(quads_busy), JW'(4'b0001));

    // Fetch cycle on quad 0
    job_fetch_request = 4'b0001;
    step();
    chk("lit fetch ack", JW'(job_fetch_ack), JW'(4'b0001));
    chk("lit fetch busy", JW'(fetch_busy), JW'(4'b0001));
    job_fetch_request = '0;
    step();
    chk("lit fetch ack one cycle", JW'(job_fetch_ack), JW'(0));
    fetch_done = 4'b0001;
    step();
    chk("lit fetch complete", JW'(job_fetch_complete), JW'(4'b0001));
    chk("lit fetch busy clear", JW'(fetch_busy), JW'(0));
    fetch_done = '0;
    step();
    job_complete = 4'b0001;
    step();
    chk("lit complete ack", JW'(job_complete_ack), JW'(4'b0001));
    job_complete = '0;
    step();
    chk("lit jobs_completed 1", JW'(jobs_completed), JW'(1));
    chk("lit idle again", JW'(idle), JW'(1));

    // Fill the FIFO with dispatch disabled, then release it
    enable         = 1'b0;
    host_job_valid = 1'b1;
    for (int i = 0; i < FD + 1; i++) begin
      host_job_data = rand_job();
      step();
    end
    chk("lit full ready low", JW'(host_job_ready), JW'(0));
    chk("lit full count", JW'(fifo_count), JW'(FD));
    chk("lit no start disabled", JW'(job_start), JW'(0));
    host_job_valid = 1'b0;
    enable         = 1'b1;
    job_accept     = 4'b1111;
    step();
    chk("lit rr resumes at q1", JW'(job_start), JW'(4'b0010));
    chk("lit ready back", JW'(host_job_ready), JW'(1));
    repeat (3) step();
    chk("lit four dispatched", JW'(fifo_count), JW'(FD - 4));
    step();
    job_complete = 4'b1001;
    step();
    chk("lit dual ack", JW'(job_complete_ack), JW'(4'b1001));
    job_complete = '0;
    step();
    chk("lit jobs_completed 3", JW'(jobs_completed), JW'(3));

    // Random traffic; counter width is small so it wraps many times
    for (int n = 0; n < 3000; n++) begin
      enable            = ($urandom_range(7) != 0);
      host_job_valid    = $urandom_range(1);
      host_job_data     = rand_job();
      job_accept        = NQ'($urandom());
      job_fetch_request = NQ'($urandom() & $urandom());
      fetch_done        = NQ'($urandom() & $urandom());
      job_complete      = NQ'($urandom() & $urandom() & $urandom());
      step();
    end

    // Reset while quad 1 is mid-fetch with one job still queued
    clear_inputs();
    rst = 1'b0;
    @(negedge clk_core);
    rst = 1'b1;
    model_reset();
    @(negedge clk_core);
    compare_all();
    job_accept     = 4'b1111;
    host_job_valid = 1'b1;
    repeat (3) begin
      host_job_data = rand_job();
      step();
    end
    host_job_valid = 1'b0;
    enable         = 1'b0;
    step();
    job_fetch_request = 4'b0010;
    step();
    chk("lit q1 fetching", JW'(fetch_busy), JW'(4'b0010));
    chk("lit one queued", JW'(fifo_count), JW'(1));
    job_fetch_request = '0;
    #2 rst = 1'b0;
    #1;
    chk("async fetch_busy", JW'(fetch_busy), JW'(0));
    chk("async quads_busy", JW'(quads_busy), JW'(0));
    chk("async fifo_count", JW'(fifo_count), JW'(0));
    chk("async idle", JW'(idle), JW'(1));
    chk("async ready", JW'(host_job_ready), JW'(1));
    chk("async params", job_parameters[JW +: JW], '0);
    chk("async fetch_ack", JW'(job_fetch_ack), JW'(0));
    @(negedge clk_core);
    rst = 1'b1;
    model_reset();
    enable       = 1'b1;
    fetch_done   = 4'b0010;
    job_complete = 4'b1111;
    repeat (4) step();
    clear_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_job_dispatch.md
Name: cnn_layer_accel_job_dispatch

Overview:
Parametrised job dispatcher sitting between the host command path and NUM_QUADS cnn_layer_accel_quad instances. It buffers incoming job descriptors in a FIFO and dispatches them round-robin to idle quads. Per quad, it runs the job_start/job_accept, job_fetch_request/ack/complete and job_complete/ack handshakes. It generalises the single-quad job handshake to N quads, with queueing, enable gating and completion accounting.

Parameters:
NUM_QUADS, 4, number of quads served (1..16)
JOB_W, 128, job descriptor width
FIFO_DEPTH, 8, job FIFO entries (power of 2, >=2)
CNT_W, 32, width of completed-job counter

Ports:
clk_core  in  1  single clock
rst  in  1  asynchronous, active-low reset
enable  in  1  1 = dispatch allowed; 0 = no new dispatch, in-flight jobs finish
host_job_valid  in  1  descriptor valid
host_job_ready  out  1  FIFO not full
host_job_data  in  JOB_W  descriptor
job_start  out  NUM_QUADS  per-quad start request
job_accept  in  NUM_QUADS  per-quad start accept
job_parameters  out  NUM_QUADS*JOB_W  per-quad descriptor, quad q at [q*JOB_W +: JOB_W]
job_fetch_request  in  NUM_QUADS  quad requests data fetch
job_fetch_ack  out  NUM_QUADS  one-cycle ack of fetch request
fetch_busy  out  NUM_QUADS  to fetch engine: fetch in progress for quad q
fetch_done  in  NUM_QUADS  from fetch engine: fetch for quad q finished (1-cycle pulse)
job_fetch_complete  out  NUM_QUADS  one-cycle pulse to quad
job_complete  in  NUM_QUADS  quad finished job
job_complete_ack  out  NUM_QUADS  one-cycle ack
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
quads_busy  out  NUM_QUADS  1 = quad not IDLE
jobs_completed  out  CNT_W  completed-job counter, wraps
idle  out  1  FIFO empty and all quads IDLE

Behaviour:
- Reset (rst=0, async): all outputs 0 except idle=1 and host_job_ready=1. FIFO is emptied, RR pointer=0, all quad FSMs go to IDLE. Reset mid-job abandons the job without an ack.
- FIFO: push on host_job_valid&host_job_ready. host_job_ready = (fifo_count<FIFO_DEPTH). Simultaneous push and pop when full is not allowed, because ready is low. Simultaneous push and pop otherwise leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Dispatch: one dispatch per cycle at most, when enable & fifo non-empty & at least one IDLE quad. The winner is the first IDLE quad at or after the RR pointer, searched modulo NUM_QUADS. On dispatch:
  - pop the FIFO head;
  - register it into job_parameters[q];
  - the quad goes to START;
  - the RR pointer moves to winner+1 (wraps).
- Latency: a descriptor pushed in cycle t has job_start high from t+2 at the earliest (registered FIFO, registered dispatch).
- Per-quad FSM:
  - IDLE: outputs low; leave only on dispatch.
  - START: job_start=1, job_parameters held stable. On job_accept -> RUN, and job_start drops the next cycle.
  - RUN: on job_fetch_request -> pulse job_fetch_ack for 1 cycle and go to FETCH. On job_complete -> DONE. If both arrive in the same cycle, job_complete wins and the request is ignored.
  - FETCH: fetch_busy=1. On fetch_done -> pulse job_fetch_complete for 1 cycle and return to RUN. fetch_done in any other state is ignored.
  - DONE: job_complete_ack=1 for exactly 1 cycle, jobs_completed++, then IDLE. The quad is eligible for dispatch in the following cycle.
- job_complete seen in FETCH is ignored; the quad must re-assert it.
- Once dispatched to START, a job is not withdrawn when enable falls.
- jobs_completed: simultaneous completions from several quads add their popcount in the same cycle. Wraps modulo 2^CNT_W.
- Outputs quads_busy, idle and fifo_count are registered.

Decomposition:
- Package cnn_layer_accel_dispatch_pkg holds:
  - quad_state_t enum {Q_IDLE, Q_START, Q_RUN, Q_FETCH, Q_DONE};
  - the default parameter constants;
  - a function rr_select(idle_vec, ptr) returning winner index and valid.
- Sub-module cnn_layer_accel_job_fifo: synchronous FIFO, parameters WIDTH/DEPTH, outputs count/full/empty. It is instantiated once.
- Per-quad FSMs come from a generate loop in the top module.

Test Plan:
- Reset then push 1 job (data=0xA5...); quad 0 accepts after 3 cycles -> job_start[0] high from t+2 to the accept cycle; job_parameters[0]=0xA5...; fifo_count returns to 0.
- Push 6 jobs with NUM_QUADS=4 and all quads accepting immediately -> dispatch order q0,q1,q2,q3; 2 jobs stay queued; after q1 completes, job 5 goes to q1; complete_ack pulses 1 cycle; jobs_completed=1.
- Fetch flow on q2: job_fetch_request -> job_fetch_ack pulse next cycle; fetch_busy[2]=1 until fetch_done; then job_fetch_complete[2] pulses once; a second request repeats the cycle.
- Fill FIFO to 8 with enable=0 -> host_job_ready=0, no job_start; enable=1 -> 4 dispatches on consecutive cycles, ready reasserts.
- q0 and q3 assert job_complete in the same cycle -> both acks pulse, jobs_completed +2; jobs_completed preloaded via force to 0xFFFFFFFF + 1 -> wraps to 0.
- Assert rst mid-FETCH on q1 -> all outputs reset immediately (async), idle=1, queued jobs lost, no spurious ack after release.
